// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default word length,
// used by both the slave and the master side of the link.
package spi_pkg;

    localparam int SPI_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI serial bus pins: the master drives clock, select and MOSI; the slave drives MISO.
interface spi_slave_if;

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the last two synchronized samples.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave, oversampled by clk.
// Define SPI_SLAVE_ERR_EN to add the frame_err abort pulse output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_slave_if.slave        spi,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
`ifdef SPI_SLAVE_ERR_EN
    logic                   frame_err_q, frame_err_d;
`endif

    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi.sclk),
        .level(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(spi.cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        hold_d      = tx_load ? tx_data : hold_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
`ifdef SPI_SLAVE_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    tx_sr_d = hold_q;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d    = DONE;
                        rx_data_d  = rx_sr_d;
                        rx_valid_d = 1'b1;
                    end
                // The fall trailing the previous word's last rise arrives after a
                // reload; only falls that follow a rise of this word shift.
                end else if (sclk_fall && cnt_q != '0) begin
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
                // A final edge coinciding with cs_n rise still delivers the word;
                // a deselect before any bit of a reloaded word is a clean end.
                if (cs_rise && state_d != DONE) begin
                    state_d = IDLE;
`ifdef SPI_SLAVE_ERR_EN
                    frame_err_d = (cnt_d != '0);
`endif
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!cs_s) begin
                    state_d = SHIFT;
                    tx_sr_d = hold_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            hold_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            mosi_sync_q <= '0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            hold_q      <= hold_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            mosi_sync_q <= mosi_sync_d;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);
    assign spi.miso = ~cs_s & tx_sr_q[DATA_W-1];
`ifdef SPI_SLAVE_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule
